baud_gen_frac: RTL and testbench
================================

Name: baud_gen_frac

Overview:
Programmable fractional-N baud/oversample tick generator. It is the next-generation replacement for the fixed-divisor baud generator.
- Produces an oversample tick (default 16x), a mid-bit sample tick and a bit-boundary tick from a runtime-loadable integer+fraction divisor.
- Feeds the UART TX (tick_baud) and RX (tick_os, tick_mid, resync on start-bit edge).

Parameters:
CLK_FREQ, 50_000_000, system clock in Hz
BAUD, 9600, reset-default baud rate
OVERSAMPLE, 16, oversample ticks per bit; power of two, >= 4
DIV_W, 16, width of integer divisor (clk cycles per oversample tick)
FRAC_W, 8, width of fractional divisor

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  generator enable
resync  in  1  realign phase; 1-cycle pulse from RX start-edge detect
cfg_valid  in  1  new divisor offered
cfg_ready  out  1  shadow register free
cfg_div_int  in  DIV_W  integer divisor
cfg_div_frac  in  FRAC_W  fractional divisor, units of 2^-FRAC_W
tick_os  out  1  oversample tick, 1-cycle pulse
tick_mid  out  1  pulse on the tick_os where os_phase becomes OVERSAMPLE/2
tick_baud  out  1  pulse on the tick_os where os_phase wraps to 0
os_phase  out  $clog2(OVERSAMPLE)  oversample index within current bit

Behaviour:
- Reset values:
  - tick_os = tick_mid = tick_baud = 0; os_phase = 0; cfg_ready = 1.
  - cnt = 0; frac_acc = 0; no shadow pending.
  - Active divisor = DEF_INT = CLK_FREQ/(BAUD*OVERSAMPLE); DEF_FRAC = ((CLK_FREQ mod (BAUD*OVERSAMPLE)) << FRAC_W)/(BAUD*OVERSAMPLE).
- Period rule:
  - Oversample period k lasts L_k = div_int + c_k cycles.
  - c_k = carry out of the FRAC_W-bit add frac_acc + div_frac; frac_acc takes the sum mod 2^FRAC_W at each tick_os.
  - Long-run average period = div_int + div_frac/2^FRAC_W.
- Counting:
  - cnt increments each cycle with en = 1.
  - When cnt == L_k-1: cnt <= 0 and tick_os is registered high for exactly the next cycle.
  - First tick_os is L_0 cycles after the first enabled cycle.
- Phase:
  - Each tick_os increments os_phase mod OVERSAMPLE, updated in the same cycle as the tick is visible.
  - tick_baud is high with the tick_os that makes os_phase 0.
  - tick_mid is high with the tick_os that makes os_phase OVERSAMPLE/2.
- All outputs are registered; no combinational path from any input to any output.
- en = 0: synchronously clears cnt, frac_acc and os_phase; all ticks 0. Re-enable restarts as from reset, with the divisor retained.
- resync = 1 while en = 1: clears cnt, frac_acc and os_phase the same cycle.
  - No tick is issued in the following cycle, even if a period boundary coincided; resync wins.
  - Next tick_os occurs L cycles after the resync cycle.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready. Divisor goes to the shadow register; cfg_ready drops the next cycle.
  - Shadow becomes the active divisor on the cycle tick_baud is issued, or on the next cycle if en = 0.
  - cfg_ready returns to 1 the cycle after the shadow is applied.
  - frac_acc is not cleared on apply.
  - A new offer while cfg_ready = 0 is held off; cfg_valid must stay high.
- Illegal divisor: div_int < 2 is clamped to 2, so a tick is never held high on consecutive cycles.
- Simultaneous events:
  - Apply and resync in the same cycle: both take effect, and the new divisor is used from the resync.
  - Reset mid-operation: everything returns to reset values immediately and the pending shadow is discarded.

Optional Feature:
BAUD_GEN_CFG_CHECK_EN
- Defined:
  - Adds output cfg_err (1 bit, reset 0).
  - A handshake with cfg_div_int < 2 completes, but the value is discarded (no shadow load, cfg_ready stays 1).
  - cfg_err sets and stays high until the next legal transfer or reset.
- Undefined: no cfg_err port; illegal values are accepted and clamped to 2.

Test Plan:
- Reset: rst_n low, then high with en = 1 and defaults (50 MHz, 9600, x16) -> DEF_INT = 325, DEF_FRAC = 133. Ticks observed at periods 325 or 326, and 16 ticks span 5208 +/- 1 cycles.
- Integer divisor: load int = 4, frac = 0, then wait for the apply -> tick_os every 4 cycles, tick_mid at os_phase 8, tick_baud every 64 cycles, cfg_ready high again 1 cycle after the apply.
- Fractional divisor: int = 4, frac = 128 (FRAC_W = 8) -> periods alternate 4, 5, 4, 5; 32 ticks take exactly 144 cycles.
- Resync: pulse resync at cnt = 2 of a 4-cycle period -> os_phase = 0 and no tick next cycle. Next tick_os 4 cycles after resync. Repeat with resync on the tick-boundary cycle -> that tick is suppressed.
- Config held off and en low: offer a second divisor while cfg_ready = 0 -> not taken until after the first apply. With en = 0, a load applies next cycle and the ticks stay 0.
- Illegal divisor: load int = 1 -> tick_os every 2 cycles (clamp). With BAUD_GEN_CFG_CHECK_EN -> cfg_err = 1 and the old divisor is kept.

Source files
------------

// File: rtl/baud_gen_frac.sv
// Fractional-N oversample/bit tick generator with a shadowed, runtime-loadable divisor.
// Optional BAUD_GEN_CFG_CHECK_EN: rejects div_int < 2 at the handshake and flags cfg_err.

module baud_gen_frac #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FRAC_W     = 8,
    localparam int unsigned PH_W      = $clog2(OVERSAMPLE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              resync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DIV_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    output logic              tick_os,
    output logic              tick_mid,
    output logic              tick_baud,
`ifdef BAUD_GEN_CFG_CHECK_EN
    output logic              cfg_err,
`endif
    output logic [PH_W-1:0]   os_phase
);

    localparam longint unsigned OsRate  = 64'(BAUD) * OVERSAMPLE;
    localparam longint unsigned DefInt  = CLK_FREQ / OsRate;
    localparam longint unsigned DefFrac = ((CLK_FREQ % OsRate) << FRAC_W) / OsRate;

    localparam logic [DIV_W-1:0]  DefIntW  = DIV_W'(DefInt);
    localparam logic [FRAC_W-1:0] DefFracW = FRAC_W'(DefFrac);
    localparam logic [PH_W-1:0]   PhMid    = PH_W'(OVERSAMPLE / 2);
    localparam logic [DIV_W-1:0]  MinDiv   = DIV_W'(2);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              tick_os_q, tick_os_d;
    logic              tick_mid_q, tick_mid_d;
    logic              tick_baud_q, tick_baud_d;

    logic [DIV_W-1:0]  div_int_q, div_int_d;
    logic [FRAC_W-1:0] div_frac_q, div_frac_d;
    logic [DIV_W-1:0]  sh_int_q, sh_int_d;
    logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
    logic              sh_pend_q, sh_pend_d;
    logic              apply_q;
    logic              cfg_ready_q, cfg_ready_d;

    logic              apply;
    logic              cfg_xfer;
    logic              cfg_legal;
    logic              wrap;
    logic [FRAC_W:0]   frac_sum;
    logic [DIV_W-1:0]  div_eff;
    logic [DIV_W:0]    period_m1;
    logic [PH_W-1:0]   phase_inc;

    // Carry of the fractional accumulator stretches the current period by one cycle.
    always_comb begin
        frac_sum  = {1'b0, acc_q} + {1'b0, div_frac_q};
        div_eff   = (div_int_q < MinDiv) ? MinDiv : div_int_q;
        period_m1 = {1'b0, div_eff} + {{DIV_W{1'b0}}, frac_sum[FRAC_W]} - (DIV_W + 1)'(1);
        wrap      = ({1'b0, cnt_q} == period_m1);
        phase_inc = phase_q + PH_W'(1);
    end

`ifdef BAUD_GEN_CFG_CHECK_EN
    assign cfg_legal = (cfg_div_int >= MinDiv);
`else
    assign cfg_legal = 1'b1;
`endif

    assign cfg_xfer = cfg_valid && cfg_ready_q;
    // Apply is decided from the boundary alone, so a coincident resync still picks it up.
    assign apply    = sh_pend_q && (!en || (wrap && (phase_inc == '0)));

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        phase_d     = phase_q;
        tick_os_d   = 1'b0;
        tick_mid_d  = 1'b0;
        tick_baud_d = 1'b0;
        if (!en) begin
            cnt_d   = '0;
            acc_d   = '0;
            phase_d = '0;
        end else if (resync) begin
            // The resync cycle itself counts as cycle 0 of the fresh period.
            cnt_d   = DIV_W'(1);
            acc_d   = '0;
            phase_d = '0;
        end else if (wrap) begin
            cnt_d       = '0;
            acc_d       = frac_sum[FRAC_W-1:0];
            phase_d     = phase_inc;
            tick_os_d   = 1'b1;
            tick_baud_d = (phase_inc == '0);
            tick_mid_d  = (phase_inc == PhMid);
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_comb begin
        div_int_d   = div_int_q;
        div_frac_d  = div_frac_q;
        sh_int_d    = sh_int_q;
        sh_frac_d   = sh_frac_q;
        sh_pend_d   = sh_pend_q;
        cfg_ready_d = cfg_ready_q;
        if (apply) begin
            div_int_d  = sh_int_q;
            div_frac_d = sh_frac_q;
            sh_pend_d  = 1'b0;
        end
        if (apply_q) begin
            cfg_ready_d = 1'b1;
        end
        if (cfg_xfer && cfg_legal) begin
            sh_int_d    = cfg_div_int;
            sh_frac_d   = cfg_div_frac;
            sh_pend_d   = 1'b1;
            cfg_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            phase_q     <= '0;
            tick_os_q   <= 1'b0;
            tick_mid_q  <= 1'b0;
            tick_baud_q <= 1'b0;
            div_int_q   <= DefIntW;
            div_frac_q  <= DefFracW;
            sh_int_q    <= '0;
            sh_frac_q   <= '0;
            sh_pend_q   <= 1'b0;
            apply_q     <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            phase_q     <= phase_d;
            tick_os_q   <= tick_os_d;
            tick_mid_q  <= tick_mid_d;
            tick_baud_q <= tick_baud_d;
            div_int_q   <= div_int_d;
            div_frac_q  <= div_frac_d;
            sh_int_q    <= sh_int_d;
            sh_frac_q   <= sh_frac_d;
            sh_pend_q   <= sh_pend_d;
            apply_q     <= apply;
            cfg_ready_q <= cfg_ready_d;
        end
    end

`ifdef BAUD_GEN_CFG_CHECK_EN
    logic cfg_err_q, cfg_err_d;

    always_comb begin
        cfg_err_d = cfg_err_q;
        if (cfg_xfer) begin
            cfg_err_d = !cfg_legal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;
`endif

    assign cfg_ready = cfg_ready_q;
    assign tick_os   = tick_os_q;
    assign tick_mid  = tick_mid_q;
    assign tick_baud = tick_baud_q;
    assign os_phase  = phase_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: tick times predicted in closed form from divisor, accumulator and phase.
// Build with BAUD_GEN_CFG_CHECK_EN defined to exercise the cfg_err variant.

module tb_baud_gen_frac;

    localparam int OS = 16;
    localparam int FM = 256;

    logic        clk = 1'b0;
    logic        rst_n, en, resync, cfg_valid, cfg_ready;
    logic [15:0] cfg_div_int;
    logic [7:0]  cfg_div_frac;
    logic        tick_os, tick_mid, tick_baud;
    logic [3:0]  os_phase;
`ifdef BAUD_GEN_CFG_CHECK_EN
    logic        cfg_err;
`endif

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    // Reference state: active divisor, accumulator and phase after the last tick at t_ref.
    int cur_int, cur_frac, acc, ph, t_ref;

    baud_gen_frac #(
        .CLK_FREQ  (50_000_000),
        .BAUD      (9600),
        .OVERSAMPLE(16),
        .DIV_W     (16),
        .FRAC_W    (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .resync      (resync),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_div_int (cfg_div_int),
        .cfg_div_frac(cfg_div_frac),
        .tick_os     (tick_os),
        .tick_mid    (tick_mid),
        .tick_baud   (tick_baud),
`ifdef BAUD_GEN_CFG_CHECK_EN
        .cfg_err     (cfg_err),
`endif
        .os_phase    (os_phase)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic step_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int deff(input int i);
        return (i < 2) ? 2 : i;
    endfunction

    function automatic int flags(input int p);
        return ((p == 0) ? 32 : 0) + ((p == OS / 2) ? 16 : 0) + p;
    endfunction

    function automatic int next_len();
        return deff(cur_int) + (((acc + cur_frac) >= FM) ? 1 : 0);
    endfunction

    // k-th tick lands after k whole periods plus the number of accumulator overflows.
    task automatic run_ticks(input string tag, input int n);
        int exp_t;
        int d;
        d = deff(cur_int);
        for (int k = 1; k <= n; k++) begin
            exp_t = t_ref + k * d + (acc + k * cur_frac) / FM;
            do step(); while (!tick_os && cyc < exp_t + 2);
            check({tag, " tick time"}, cyc, exp_t);
            check({tag, " phase/flags"}, int'({tick_baud, tick_mid, os_phase}),
                  flags((ph + k) % OS));
            if (!tick_os) break;
        end
        t_ref = t_ref + n * d + (acc + n * cur_frac) / FM;
        acc   = (acc + n * cur_frac) % FM;
        ph    = (ph + n) % OS;
    endtask

    task automatic offer(input int i, input int f);
        cfg_div_int  = 16'(i);
        cfg_div_frac = 8'(f);
        cfg_valid    = 1'b1;
        step();
        cfg_valid    = 1'b0;
    endtask

    task automatic load_and_run(input string tag, input int i, input int f, input int n);
        offer(i, f);
        check({tag, " ready drop"}, cfg_ready, 0);
        run_ticks({tag, " old"}, OS - ph);
        check({tag, " ready at apply"}, cfg_ready, 0);
        cur_int  = i;
        cur_frac = f;
        step();
        check({tag, " ready back"}, cfg_ready, 1);
        run_ticks({tag, " new"}, n);
    endtask

    task automatic pulse_resync(input string tag);
        resync = 1'b1;
        t_ref  = cyc;
        step();
        resync = 1'b0;
        check({tag, " no tick"}, tick_os, 0);
        check({tag, " phase"}, os_phase, 0);
        acc = 0;
        ph  = 0;
    endtask

    initial begin
        int seen;
        int ri, rf, ro;
        rst_n = 1'b0; en = 1'b0; resync = 1'b0; cfg_valid = 1'b0;
        cfg_div_int = '0; cfg_div_frac = '0;
        repeat (3) step();
        check("reset tick_os", tick_os, 0);
        check("reset flags", int'({tick_baud, tick_mid, os_phase}), 0);
        check("reset ready", cfg_ready, 1);
`ifdef BAUD_GEN_CFG_CHECK_EN
        check("reset cfg_err", cfg_err, 0);
`endif

        // Defaults: 325 + 133/256 cycles per oversample tick.
        rst_n = 1'b1; en = 1'b1;
        t_ref = cyc; acc = 0; ph = 0; cur_int = 325; cur_frac = 133;
        run_ticks("default", 16);

        load_and_run("int4", 4, 0, 32);
        load_and_run("frac", 4, 128, 32);

        step_to(t_ref + 2);
        pulse_resync("resync mid");
        run_ticks("after resync mid", 8);

        step_to(t_ref + next_len() - 1);
        pulse_resync("resync edge");
        run_ticks("after resync edge", 8);

        // Resync lands on the very cycle the shadow is applied.
        offer(6, 200);
        check("apply+resync ready drop", cfg_ready, 0);
        run_ticks("apply+resync pre", (15 - ph + OS) % OS);
        step_to(t_ref + next_len() - 1);
        pulse_resync("apply+resync");
        cur_int = 6; cur_frac = 200;
        check("apply+resync ready low", cfg_ready, 0);
        step();
        check("apply+resync ready back", cfg_ready, 1);
        run_ticks("apply+resync post", 16);

        // Second offer held off while the first is still pending.
        cfg_div_int = 16'd3; cfg_div_frac = 8'd0; cfg_valid = 1'b1;
        step();
        cfg_div_int = 16'd5; cfg_div_frac = 8'd64;
        check("held ready drop", cfg_ready, 0);
        run_ticks("held old", OS - ph);
        check("held ready at apply", cfg_ready, 0);
        cur_int = 3; cur_frac = 0;
        step();
        check("held ready back", cfg_ready, 1);
        step();
        check("held second taken", cfg_ready, 0);
        cfg_valid = 1'b0;
        run_ticks("held first", 16);
        check("held second apply ready", cfg_ready, 0);
        cur_int = 5; cur_frac = 64;
        step();
        check("held second ready back", cfg_ready, 1);
        run_ticks("held second", 16);

        // Disabled: load applies without a baud tick, outputs stay quiet.
        en = 1'b0;
        step();
        check("en low tick", tick_os, 0);
        check("en low phase", os_phase, 0);
        offer(5, 0);
        check("en low ready drop", cfg_ready, 0);
        step();
        step();
        check("en low ready back", cfg_ready, 1);
        seen = 0;
        repeat (10) begin
            step();
            seen += int'(tick_os);
        end
        check("en low tick count", seen, 0);
        en = 1'b1;
        t_ref = cyc; acc = 0; ph = 0; cur_int = 5; cur_frac = 0;
        run_ticks("reenable", 16);

`ifdef BAUD_GEN_CFG_CHECK_EN
        offer(1, 0);
        check("illegal ready kept", cfg_ready, 1);
        check("illegal cfg_err", cfg_err, 1);
        run_ticks("illegal old kept", 16);
        offer(7, 10);
        check("legal clears cfg_err", cfg_err, 0);
        check("legal ready drop", cfg_ready, 0);
        run_ticks("legal old", OS - ph);
        cur_int = 7; cur_frac = 10;
        step();
        check("legal ready back", cfg_ready, 1);
        run_ticks("legal new", 16);
`else
        load_and_run("clamp", 1, 0, 32);
`endif

        for (int r = 0; r < 3; r++) begin
            ri = int'($urandom_range(2, 12));
            rf = int'($urandom_range(0, 255));
            load_and_run("random", ri, rf, 20);
            ro = int'($urandom_range(1, next_len() - 1));
            step_to(t_ref + ro);
            pulse_resync("random resync");
            run_ticks("random after resync", 12);
        end

        // Reset with a shadow pending: the pending divisor must be dropped.
        offer(9, 9);
        check("pre reset ready drop", cfg_ready, 0);
        step();
        rst_n = 1'b0;
        step();
        check("mid reset tick", tick_os, 0);
        check("mid reset flags", int'({tick_baud, tick_mid, os_phase}), 0);
        check("mid reset ready", cfg_ready, 1);
        rst_n = 1'b1;
        t_ref = cyc; acc = 0; ph = 0; cur_int = 325; cur_frac = 133;
        run_ticks("post reset", 18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
